snn_inference_sequencer: RTL and testbench

- Sequences one inference of the multi-layer IF spiking network.
- Holds the network in reset between samples and streams NUM_TIMESTEPS input spike vectors into it through a valid/ready handshake.
- Drains the layer pipeline, counts output spikes per output neuron, then scans the counts and reports the winning class.
- Sits between the spike encoder (upstream) and the network instance, which it drives directly.

---
 rtl/snn_inference_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_snn_inference_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_inference_sequencer.sv
// Sequences one inference of the IF spiking network: streams timestep vectors in,
// drains the layer pipeline, counts output spikes per neuron and scans for the winner.
module snn_inference_sequencer #(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_OUTPUTS   = 4,
    parameter int NUM_TIMESTEPS = 16,
    parameter int DRAIN_CYCLES  = 3,
    parameter int COUNT_WIDTH   = 8,
    localparam int IDX_W        = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic                               in_valid_i,
    input  logic [NUM_INPUTS-1:0]              in_spikes_i,
    output logic                               in_ready_o,
    output logic                               net_rst_o,
    output logic [NUM_INPUTS-1:0]              net_spike_in_o,
    input  logic [NUM_OUTPUTS-1:0]             net_spike_out_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               result_valid_o,
    output logic [IDX_W-1:0]                   winner_o,
    output logic                               no_spike_o,
    output logic [NUM_OUTPUTS*COUNT_WIDTH-1:0] spike_counts_o
);

    localparam int TS_W = $clog2(NUM_TIMESTEPS + 1);
    localparam int DR_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_EVAL,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [TS_W-1:0]         tsCount_q, tsCount_d;
    logic [DR_W-1:0]         drainCount_q, drainCount_d;
    logic [IDX_W-1:0]        scanIdx_q, scanIdx_d;
    logic [COUNT_WIDTH-1:0]  maxVal_q, maxVal_d;
    logic [IDX_W-1:0]        maxIdx_q, maxIdx_d;
    logic [COUNT_WIDTH-1:0]  counts_q [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0]  counts_d [NUM_OUTPUTS];
    logic                    netRst_q, netRst_d;
    logic [NUM_INPUTS-1:0]   netSpikeIn_q, netSpikeIn_d;
    logic                    done_q, done_d;
    logic                    resultValid_q, resultValid_d;
    logic [IDX_W-1:0]        winner_q, winner_d;
    logic                    noSpike_q, noSpike_d;

    logic [COUNT_WIDTH-1:0]  candVal;
    logic [IDX_W-1:0]        candIdx;

    // Next-state logic: handshake, spike counting, drain timing and the winner scan.
    always_comb begin
        state_d       = state_q;
        tsCount_d     = tsCount_q;
        drainCount_d  = drainCount_q;
        scanIdx_d     = scanIdx_q;
        maxVal_d      = maxVal_q;
        maxIdx_d      = maxIdx_q;
        counts_d      = counts_q;
        netRst_d      = netRst_q;
        netSpikeIn_d  = '0;
        done_d        = 1'b0;
        resultValid_d = resultValid_q;
        winner_d      = winner_q;
        noSpike_d     = noSpike_q;

        // Ties keep the earlier (lower) index; neuron 0 seeds the running max.
        candVal = maxVal_q;
        candIdx = maxIdx_q;
        if ((scanIdx_q == '0) || (counts_q[scanIdx_q] > maxVal_q)) begin
            candVal = counts_q[scanIdx_q];
            candIdx = scanIdx_q;
        end

        if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (net_spike_out_i[k] && (counts_q[k] != CNT_MAX)) begin
                    counts_d[k] = counts_q[k] + 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                netRst_d = 1'b1;
                if (start_i) begin
                    state_d       = S_RUN;
                    tsCount_d     = '0;
                    resultValid_d = 1'b0;
                    noSpike_d     = 1'b0;
                    netRst_d      = 1'b0;
                    for (int k = 0; k < NUM_OUTPUTS; k++) begin
                        counts_d[k] = '0;
                    end
                end
            end
            S_RUN: begin
                if (in_valid_i) begin
                    netSpikeIn_d = in_spikes_i;
                    tsCount_d    = tsCount_q + 1'b1;
                    if (tsCount_q == TS_W'(NUM_TIMESTEPS - 1)) begin
                        state_d      = S_DRAIN;
                        drainCount_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drainCount_q == DR_W'(DRAIN_CYCLES - 1)) begin
                    state_d   = S_EVAL;
                    netRst_d  = 1'b1;
                    scanIdx_d = '0;
                end else begin
                    drainCount_d = drainCount_q + 1'b1;
                end
            end
            S_EVAL: begin
                maxVal_d = candVal;
                maxIdx_d = candIdx;
                if (scanIdx_q == IDX_W'(NUM_OUTPUTS - 1)) begin
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                    resultValid_d = 1'b1;
                    winner_d      = candIdx;
                    noSpike_d     = (candVal == '0);
                end else begin
                    scanIdx_d = scanIdx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset holds the network in reset and discards partial counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tsCount_q     <= '0;
            drainCount_q  <= '0;
            scanIdx_q     <= '0;
            maxVal_q      <= '0;
            maxIdx_q      <= '0;
            counts_q      <= '{default: '0};
            netRst_q      <= 1'b1;
            netSpikeIn_q  <= '0;
            done_q        <= 1'b0;
            resultValid_q <= 1'b0;
            winner_q      <= '0;
            noSpike_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tsCount_q     <= tsCount_d;
            drainCount_q  <= drainCount_d;
            scanIdx_q     <= scanIdx_d;
            maxVal_q      <= maxVal_d;
            maxIdx_q      <= maxIdx_d;
            counts_q      <= counts_d;
            netRst_q      <= netRst_d;
            netSpikeIn_q  <= netSpikeIn_d;
            done_q        <= done_d;
            resultValid_q <= resultValid_d;
            winner_q      <= winner_d;
            noSpike_q     <= noSpike_d;
        end
    end

    // Flatten the per-neuron counters onto the output bus, neuron k at bits [k*CW +: CW].
    always_comb begin
        spike_counts_o = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            spike_counts_o[k*COUNT_WIDTH +: COUNT_WIDTH] = counts_q[k];
        end
    end

    assign in_ready_o     = (state_q == S_RUN);
    assign busy_o         = (state_q != S_IDLE);
    assign net_rst_o      = netRst_q;
    assign net_spike_in_o = netSpikeIn_q;
    assign done_o         = done_q;
    assign result_valid_o = resultValid_q;
    assign winner_o       = winner_q;
    assign no_spike_o     = noSpike_q;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Self-checking bench for snn_inference_sequencer: table of directed inferences plus
// hand-written reset sequences.
module tb_snn_inference_sequencer;

    localparam int NIN      = 4;
    localparam int NOUT     = 4;
    localparam int NTS      = 16;
    localparam int NDR      = 3;
    localparam int CW       = 8;
    localparam int NUM_VECS = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic [NIN-1:0]       in_spikes;
    logic                 in_ready;
    logic                 net_rst;
    logic [NIN-1:0]       net_spike_in;
    logic [NOUT-1:0]      net_spike_out;
    logic                 busy;
    logic                 done;
    logic                 result_valid;
    logic [1:0]           winner;
    logic                 no_spike;
    logic [NOUT*CW-1:0]   spike_counts;

    // Each record: per-neuron number of leading cycles it spikes, valid pattern,
    // whether start is pulsed mid-run, and hand-computed results.
    typedef struct {
        logic [NOUT-1:0][31:0] active;
        int                    validMode;
        bit                    startNoise;
        logic [NOUT-1:0][31:0] expCounts;
        int                    expWinner;
        bit                    expNoSpike;
    } vec_t;

    vec_t vecs [NUM_VECS];
    int   numChecks = 0;
    int   numFails  = 0;

    snn_inference_sequencer #(
        .NUM_INPUTS    (NIN),
        .NUM_OUTPUTS   (NOUT),
        .NUM_TIMESTEPS (NTS),
        .DRAIN_CYCLES  (NDR),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .in_valid_i      (in_valid),
        .in_spikes_i     (in_spikes),
        .in_ready_o      (in_ready),
        .net_rst_o       (net_rst),
        .net_spike_in_o  (net_spike_in),
        .net_spike_out_i (net_spike_out),
        .busy_o          (busy),
        .done_o          (done),
        .result_valid_o  (result_valid),
        .winner_o        (winner),
        .no_spike_o      (no_spike),
        .spike_counts_o  (spike_counts)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hang guard: should never fire in a healthy run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(int a0, int a1, int a2, int a3, int mode, bit noise,
                                int c0, int c1, int c2, int c3, int win, bit ns);
        vec_t r;
        r.active[0]    = a0;
        r.active[1]    = a1;
        r.active[2]    = a2;
        r.active[3]    = a3;
        r.validMode    = mode;
        r.startNoise   = noise;
        r.expCounts[0] = c0;
        r.expCounts[1] = c1;
        r.expCounts[2] = c2;
        r.expCounts[3] = c3;
        r.expWinner    = win;
        r.expNoSpike   = ns;
        return r;
    endfunction

    // Valid patterns: 0 = always, 1 = alternating starting high, 2 = low for 300 cycles.
    function automatic bit validAt(int mode, int i);
        case (mode)
            0:       return 1'b1;
            1:       return (i % 2) == 1;
            default: return i > 300;
        endcase
    endfunction

    function automatic logic [NIN-1:0] spk(int i);
        return NIN'((i * 5 + 3) % 16);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one inference from the table; entered and left one time unit after a rising edge.
    task automatic applyStimulus(input int idx);
        vec_t           v;
        int             runLen;
        int             acc;
        int             latency;
        logic [NIN-1:0] expNsi;
        v      = vecs[idx];
        runLen = 0;
        acc    = 0;
        while (acc < NTS) begin
            runLen++;
            if (validAt(v.validMode, runLen)) acc++;
        end
        latency = runLen + NDR + NOUT + 1;

        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= latency + 1; i++) begin
            #1;
            start     = v.startNoise && ((i == 5) || (i == runLen + 2));
            in_valid  = validAt(v.validMode, i);
            in_spikes = spk(i);
            for (int k = 0; k < NOUT; k++) begin
                net_spike_out[k] = (i <= int'(v.active[k]));
            end
            if (i <= latency) begin
                checkOutput($sformatf("v%0d c%0d in_ready", idx, i), 32'(in_ready), 32'(i <= runLen));
                checkOutput($sformatf("v%0d c%0d net_rst", idx, i), 32'(net_rst), 32'(i > runLen + NDR));
                checkOutput($sformatf("v%0d c%0d busy", idx, i), 32'(busy), 32'(1));
                checkOutput($sformatf("v%0d c%0d done", idx, i), 32'(done), 32'(i == latency));
                expNsi = ((i > 1) && (i - 1 <= runLen) && validAt(v.validMode, i - 1)) ? spk(i - 1) : '0;
                checkOutput($sformatf("v%0d c%0d net_spike_in", idx, i), 32'(net_spike_in), 32'(expNsi));
                if (i < latency) begin
                    checkOutput($sformatf("v%0d c%0d result_valid", idx, i), 32'(result_valid), 32'(0));
                end
            end else begin
                checkOutput($sformatf("v%0d end busy", idx), 32'(busy), 32'(0));
                checkOutput($sformatf("v%0d end done", idx), 32'(done), 32'(0));
                checkOutput($sformatf("v%0d end result_valid", idx), 32'(result_valid), 32'(1));
                checkOutput($sformatf("v%0d end winner", idx), 32'(winner), 32'(v.expWinner));
                checkOutput($sformatf("v%0d end no_spike", idx), 32'(no_spike), 32'(v.expNoSpike));
                for (int k = 0; k < NOUT; k++) begin
                    checkOutput($sformatf("v%0d end count%0d", idx, k),
                                32'(spike_counts[k*CW +: CW]), v.expCounts[k]);
                end
            end
            @(posedge clk);
        end
        #1;
        start         = 1'b0;
        in_valid      = 1'b0;
        in_spikes     = '0;
        net_spike_out = '0;
    endtask

    // Main sequence: reset values, table of inferences, reset mid-run, recovery, saturation.
    initial begin
        bit sawDone;
        vecs[0] = mk(0, 0, 100, 0,    0, 1'b0,  0, 0, 19, 0,      2, 1'b0);
        vecs[1] = mk(5, 7, 7, 3,      0, 1'b0,  5, 7, 7, 3,       1, 1'b0);
        vecs[2] = mk(0, 0, 0, 0,      0, 1'b0,  0, 0, 0, 0,       0, 1'b1);
        vecs[3] = mk(40, 10, 34, 33,  1, 1'b0,  34, 10, 34, 33,   0, 1'b0);
        vecs[4] = mk(1, 2, 3, 19,     0, 1'b1,  1, 2, 3, 19,      3, 1'b0);
        vecs[5] = mk(400, 0, 255, 254, 2, 1'b0, 255, 0, 255, 254, 0, 1'b0);

        rst           = 1'b1;
        start         = 1'b0;
        in_valid      = 1'b0;
        in_spikes     = '0;
        net_spike_out = '0;
        #2;
        checkOutput("reset net_rst", 32'(net_rst), 32'(1));
        checkOutput("reset busy", 32'(busy), 32'(0));
        checkOutput("reset in_ready", 32'(in_ready), 32'(0));
        checkOutput("reset done", 32'(done), 32'(0));
        checkOutput("reset result_valid", 32'(result_valid), 32'(0));
        checkOutput("reset winner", 32'(winner), 32'(0));
        checkOutput("reset no_spike", 32'(no_spike), 32'(0));
        checkOutput("reset counts", spike_counts, 32'(0));
        checkOutput("reset net_spike_in", 32'(net_spike_in), 32'(0));
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < NUM_VECS - 1; v++) begin
            applyStimulus(v);
        end

        $display("[TB] reset during RUN after five accepts");
        start = 1'b1;
        @(posedge clk);
        #1;
        start         = 1'b0;
        in_valid      = 1'b1;
        in_spikes     = 4'b1010;
        net_spike_out = '1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midrst pre count0", 32'(spike_counts[0 +: CW]), 32'(5));
        checkOutput("midrst pre busy", 32'(busy), 32'(1));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst net_rst", 32'(net_rst), 32'(1));
        checkOutput("midrst busy", 32'(busy), 32'(0));
        checkOutput("midrst in_ready", 32'(in_ready), 32'(0));
        checkOutput("midrst counts", spike_counts, 32'(0));
        checkOutput("midrst result_valid", 32'(result_valid), 32'(0));
        checkOutput("midrst winner", 32'(winner), 32'(0));
        checkOutput("midrst net_spike_in", 32'(net_spike_in), 32'(0));
        in_valid      = 1'b0;
        net_spike_out = '0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        sawDone = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("midrst no later done/busy", 32'(sawDone), 32'(0));

        applyStimulus(0);
        applyStimulus(NUM_VECS - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
